// File: rtl/writeback_unit.sv
// Writeback stage: returns ALU/PC+4 results directly and runs one outstanding
// data-memory load with alignment checks, lane formatting, bus-error and timeout.
module writeback_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_pc4_i,
  input  logic [1:0]  ex_wb_sel_i,
  input  logic [2:0]  ex_ld_type_i,
  input  logic        ex_rf_we_i,
  input  logic [4:0]  ex_rd_i,
  output logic        dmem_req_o,
  output logic [31:0] dmem_addr_o,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  input  logic [31:0] dmem_data_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [2:0]  r_ld_type;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic        r_we;

  logic        w_accept, w_is_load, w_is_byte, w_is_half, w_misaligned, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_accept && w_is_load && !w_misaligned) w_next = LOAD_WAIT;
      LOAD_WAIT: if (dmem_ack_i || w_timeout) w_next = IDLE;
    endcase
  end

  always_comb begin
    ex_ready_o   = (r_state == IDLE) && !rst_i;
    w_accept     = ex_valid_i && ex_ready_o;
    w_is_load    = (ex_wb_sel_i == 2'b01);
    w_is_byte    = (ex_ld_type_i == 3'b000) || (ex_ld_type_i == 3'b100);
    w_is_half    = (ex_ld_type_i == 3'b001) || (ex_ld_type_i == 3'b101);
    // Every type that is neither byte nor half behaves as a word access.
    w_misaligned = w_is_byte ? 1'b0 :
                   w_is_half ? ex_alu_result_i[0] : (ex_alu_result_i[1:0] != 2'b00);
    w_timeout    = (r_state == LOAD_WAIT) && !dmem_ack_i && (r_cnt == CNT_LAST);
  end

  always_comb begin
    w_byte = '0;
    unique case (r_lane)
      2'd0: w_byte = dmem_data_i[7:0];
      2'd1: w_byte = dmem_data_i[15:8];
      2'd2: w_byte = dmem_data_i[23:16];
      2'd3: w_byte = dmem_data_i[31:24];
    endcase
    w_half = r_lane[1] ? dmem_data_i[31:16] : dmem_data_i[15:0];
    case (r_ld_type)
      3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_fmt = {24'b0, w_byte};
      3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_fmt = {16'b0, w_half};
      default: w_fmt = dmem_data_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt        <= '0;
      r_ld_type    <= '0;
      r_lane       <= '0;
      r_rd         <= '0;
      r_we         <= 1'b0;
      rf_we_o      <= 1'b0;
      rf_rd_o      <= '0;
      rf_data_o    <= '0;
      dmem_req_o   <= 1'b0;
      dmem_addr_o  <= '0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      rf_we_o      <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      if (w_accept) begin
        if (!w_is_load) begin
          if (ex_rf_we_i && (ex_rd_i != 5'd0)) begin
            rf_we_o   <= 1'b1;
            rf_rd_o   <= ex_rd_i;
            rf_data_o <= (ex_wb_sel_i == 2'b10) ? ex_pc4_i : ex_alu_result_i;
          end
        end else if (w_misaligned) begin
          misaligned_o <= 1'b1;
        end else begin
          dmem_req_o  <= 1'b1;
          dmem_addr_o <= {ex_alu_result_i[31:2], 2'b00};
          r_cnt       <= '0;
          r_ld_type   <= ex_ld_type_i;
          r_lane      <= ex_alu_result_i[1:0];
          r_rd        <= ex_rd_i;
          r_we        <= ex_rf_we_i && (ex_rd_i != 5'd0);
        end
      end else if (r_state == LOAD_WAIT) begin
        if (dmem_ack_i) begin
          dmem_req_o <= 1'b0;
          if (dmem_err_i) begin
            bus_err_o <= 1'b1;
          end else if (r_we) begin
            rf_we_o   <= 1'b1;
            rf_rd_o   <= r_rd;
            rf_data_o <= w_fmt;
          end
        end else if (w_timeout) begin
          bus_err_o  <= 1'b1;
          dmem_req_o <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: transaction-level driver maintains expected outputs;
// a negedge process compares every output each cycle, plus directed literal checks.
module tb_writeback_unit;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_alu_result_i;
  logic [31:0] ex_pc4_i;
  logic [1:0]  ex_wb_sel_i;
  logic [2:0]  ex_ld_type_i;
  logic        ex_rf_we_i;
  logic [4:0]  ex_rd_i;
  logic        dmem_req_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_ack_i;
  logic        dmem_err_i;
  logic [31:0] dmem_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic        misaligned_o;
  logic        bus_err_o;

  writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_alu_result_i(ex_alu_result_i), .ex_pc4_i(ex_pc4_i),
    .ex_wb_sel_i(ex_wb_sel_i), .ex_ld_type_i(ex_ld_type_i),
    .ex_rf_we_i(ex_rf_we_i), .ex_rd_i(ex_rd_i),
    .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o),
    .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i), .dmem_data_i(dmem_data_i),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic        exp_we, exp_req, exp_mis, exp_berr, exp_ready;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk1("ex_ready", ex_ready_o, exp_ready);
    chk1("rf_we", rf_we_o, exp_we);
    chk ("rf_rd", {27'b0, rf_rd_o}, {27'b0, exp_rd});
    chk ("rf_data", rf_data_o, exp_data);
    chk1("dmem_req", dmem_req_o, exp_req);
    chk1("misaligned", misaligned_o, exp_mis);
    chk1("bus_err", bus_err_o, exp_berr);
    if (exp_req) chk("dmem_addr", dmem_addr_o, exp_addr);
  end

  // Reference load formatting: shift the addressed lane down, then extend.
  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [2:0] ty,
                                          input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    if (ty == 3'b000) return b | (b[7]  ? 32'hFFFF_FF00 : 32'h0);
    if (ty == 3'b100) return b;
    if (ty == 3'b001) return h | (h[15] ? 32'hFFFF_0000 : 32'h0);
    if (ty == 3'b101) return h;
    return w;
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] ty, input logic [31:0] a);
    int unsigned size;
    size = (ty == 3'b000 || ty == 3'b100) ? 1 : (ty == 3'b001 || ty == 3'b101) ? 2 : 4;
    return (a % size) != 0;
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
    exp_we = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
  endtask

  task automatic junk_inputs;
    ex_valid_i      = 1'($urandom_range(0, 1));
    ex_alu_result_i = $urandom;
    ex_pc4_i        = $urandom;
    ex_wb_sel_i     = 2'($urandom_range(0, 3));
    ex_ld_type_i    = 3'($urandom_range(0, 7));
    ex_rf_we_i      = 1'b1;
    ex_rd_i         = 5'($urandom_range(1, 31));
  endtask

  task automatic do_nonload(input logic [1:0] sel, input logic [31:0] alu,
                            input logic [31:0] pc4, input logic we, input logic [4:0] rd);
    ex_valid_i = 1'b1; ex_wb_sel_i = sel; ex_alu_result_i = alu; ex_pc4_i = pc4;
    ex_rf_we_i = we; ex_rd_i = rd; ex_ld_type_i = 3'($urandom_range(0, 7));
    dmem_ack_i = 1'($urandom_range(0, 1)); dmem_err_i = 1'($urandom_range(0, 1));
    dmem_data_i = $urandom;
    tick;
    if (we && rd != 0) begin
      exp_we = 1'b1; exp_rd = rd; exp_data = (sel == 2'b10) ? pc4 : alu;
    end
    exp_ready = 1'b1;
    ex_valid_i = 1'b0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
  endtask

  // delay = LOAD_WAIT cycles that pass before the cycle in which ack is driven.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] ty, input logic [31:0] data,
                         input int unsigned delay, input logic err, input logic we,
                         input logic [4:0] rd);
    ex_valid_i = 1'b1; ex_wb_sel_i = 2'b01; ex_alu_result_i = addr; ex_ld_type_i = ty;
    ex_rf_we_i = we; ex_rd_i = rd; ex_pc4_i = $urandom;
    tick;
    if (ref_misaligned(ty, addr)) begin
      exp_mis = 1'b1; exp_ready = 1'b1; ex_valid_i = 1'b0;
      return;
    end
    exp_req = 1'b1; exp_addr = addr & 32'hFFFF_FFFC; exp_ready = 1'b0;
    for (int unsigned k = 0; k < TO; k++) begin
      junk_inputs;
      if (k == delay) begin
        dmem_ack_i = 1'b1; dmem_err_i = err; dmem_data_i = data;
      end else begin
        dmem_ack_i = 1'b0; dmem_err_i = 1'($urandom_range(0, 1)); dmem_data_i = $urandom;
      end
      tick;
      if (k == delay) begin
        exp_req = 1'b0; exp_ready = 1'b1;
        if (err) exp_berr = 1'b1;
        else if (we && rd != 0) begin
          exp_we = 1'b1; exp_rd = rd; exp_data = ref_fmt(data, ty, addr);
        end
        break;
      end else if (k + 1 == TO) begin
        exp_berr = 1'b1; exp_req = 1'b0; exp_ready = 1'b1;
      end
    end
    ex_valid_i = 1'b0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; ex_valid_i = 1'b0; ex_alu_result_i = '0; ex_pc4_i = '0;
    ex_wb_sel_i = '0; ex_ld_type_i = '0; ex_rf_we_i = 1'b0; ex_rd_i = '0;
    dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_data_i = '0;
    exp_we = 1'b0; exp_req = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0; exp_ready = 1'b0;
    exp_rd = '0; exp_data = '0; exp_addr = '0;
    tick; tick;
    rst_i = 1'b0; exp_ready = 1'b1;
    tick;

    do_nonload(2'b00, 32'h0000_1234, 32'h0000_0AAA, 1'b1, 5'd5);
    chk1("alu_we", rf_we_o, 1'b1);
    chk ("alu_rd", {27'b0, rf_rd_o}, 32'd5);
    chk ("alu_data", rf_data_o, 32'h0000_1234);
    tick;
    chk1("alu_we_once", rf_we_o, 1'b0);

    do_load(32'h0000_0103, 3'b000, 32'h80AA_BBCC, 2, 1'b0, 1'b1, 5'd7);
    chk1("lb_we", rf_we_o, 1'b1);
    chk ("lb_data", rf_data_o, 32'hFFFF_FF80);
    chk ("lb_addr", dmem_addr_o, 32'h0000_0100);

    do_load(32'h0000_0102, 3'b010, 32'h1111_2222, 0, 1'b0, 1'b1, 5'd9);
    chk1("lw_mis", misaligned_o, 1'b1);
    chk1("lw_mis_noreq", dmem_req_o, 1'b0);
    tick;

    do_load(32'h0000_0202, 3'b101, 32'h0, TO + 5, 1'b0, 1'b1, 5'd3);
    chk1("lhu_timeout", bus_err_o, 1'b1);
    chk1("lhu_timeout_nowe", rf_we_o, 1'b0);

    do_nonload(2'b00, 32'hDEAD_0001, 32'h0, 1'b1, 5'd0);
    chk1("rd0_nowe", rf_we_o, 1'b0);
    do_nonload(2'b00, 32'h0000_0011, 32'h0, 1'b1, 5'd1);
    chk1("b2b_1", rf_we_o, 1'b1);
    do_nonload(2'b10, 32'h0, 32'h0000_0404, 1'b1, 5'd2);
    chk ("b2b_2_pc4", rf_data_o, 32'h0000_0404);
    do_nonload(2'b11, 32'h0000_0033, 32'h0, 1'b1, 5'd3);
    chk1("b2b_3", rf_we_o, 1'b1);

    do_load(32'h0000_0400, 3'b010, 32'hCAFE_F00D, 1, 1'b1, 1'b1, 5'd4);
    chk1("berr_pulse", bus_err_o, 1'b1);

    // Reset in the middle of a load, then a stale ack after release.
    ex_valid_i = 1'b1; ex_wb_sel_i = 2'b01; ex_alu_result_i = 32'h0000_0300;
    ex_ld_type_i = 3'b010; ex_rf_we_i = 1'b1; ex_rd_i = 5'd6;
    tick;
    exp_req = 1'b1; exp_addr = 32'h0000_0300; exp_ready = 1'b0; ex_valid_i = 1'b0;
    tick;
    #1;
    rst_i = 1'b1;
    exp_req = 1'b0; exp_ready = 1'b0; exp_rd = '0; exp_data = '0;
    #1;
    chk1("rst_req", dmem_req_o, 1'b0);
    chk ("rst_data", rf_data_o, 32'h0);
    chk1("rst_ready", ex_ready_o, 1'b0);
    tick; tick;
    rst_i = 1'b0; exp_ready = 1'b1;
    dmem_ack_i = 1'b1; dmem_err_i = 1'b0; dmem_data_i = 32'h5555_AAAA;
    tick;
    dmem_ack_i = 1'b0;
    chk1("late_ack_nowe", rf_we_o, 1'b0);
    chk1("late_ack_noberr", bus_err_o, 1'b0);
    tick;

    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 9) < 5) begin
        int unsigned s;
        s = $urandom_range(0, 2);
        do_nonload((s == 0) ? 2'b00 : (s == 1) ? 2'b10 : 2'b11, $urandom, $urandom,
                   1'($urandom_range(0, 1)), rd);
      end else begin
        do_load($urandom, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, TO + 1),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rd);
      end
      if ($urandom_range(0, 3) == 0) tick;
    end
    tick; tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
